// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: default widths, jump-bit field positions and
// the program-counter sequencer state encoding.
package hack_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 15;

   localparam int J_LT = 2;
   localparam int J_EQ = 1;
   localparam int J_GT = 0;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;
endpackage

// File: rtl/jump_cond.sv
// Hack jump-condition decode: a C-instruction jumps when any selected
// relation (lt/eq/gt) of the ALU result holds.
module jump_cond
   import hack_pkg::*;
(
   input  logic       i_is_c,
   input  logic [2:0] i_jmp,
   input  logic       i_zr,
   input  logic       i_ng,
   output logic       o_take
);
   logic w_lt;
   logic w_eq;
   logic w_gt;

   assign w_lt   = i_jmp[J_LT] & i_ng;
   assign w_eq   = i_jmp[J_EQ] & i_zr;
   assign w_gt   = i_jmp[J_GT] & ~i_ng & ~i_zr;
   assign o_take = i_is_c & (w_lt | w_eq | w_gt);
endmodule

// File: rtl/pc_sequencer.sv
// Hack program-counter stage: PC register with stall, jump and jump-to-self
// halt handling, plus a saturating retired-instruction counter.
module pc_sequencer
   import hack_pkg::*;
#(
   parameter int DATA_W = hack_pkg::DATA_W,
   parameter int ADDR_W = hack_pkg::ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] target,
   input  logic              is_c,
   input  logic [2:0]        jmp,
   input  logic              zr,
   input  logic              ng,
   input  logic              stall,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   output logic              jump_taken,
   output logic              halted,
   output logic [CNT_W-1:0]  retired,
   output logic [1:0]        dbg_state
);
   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic                r_jump_taken;
   logic                w_jump_taken_nxt;
   logic [CNT_W-1:0]    r_retired;
   logic [CNT_W-1:0]    w_retired_nxt;
   logic                w_take;
   logic [ADDR_W-1:0]   w_tgt;

   jump_cond u_jump_cond (
      .i_is_c (is_c),
      .i_jmp  (jmp),
      .i_zr   (zr),
      .i_ng   (ng),
      .o_take (w_take)
   );

   assign w_tgt = target[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_RST;
         r_pc         <= '0;
         r_jump_taken <= 1'b0;
         r_retired    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_jump_taken <= w_jump_taken_nxt;
         r_retired    <= w_retired_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_jump_taken_nxt = r_jump_taken;
      w_retired_nxt    = r_retired;
      case (r_state)
         ST_RST: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!stall) begin
               // The jump-to-self instruction still retires before the freeze.
               if (r_retired != {CNT_W{1'b1}}) begin
                  w_retired_nxt = r_retired + CNT_W'(1);
               end
               if (w_take) begin
                  w_pc_nxt         = w_tgt;
                  w_jump_taken_nxt = 1'b1;
                  if (w_tgt == r_pc) begin
                     w_state_nxt = ST_HALT;
                  end
               end else begin
                  w_pc_nxt         = r_pc + ADDR_W'(1);
                  w_jump_taken_nxt = 1'b0;
               end
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_RST;
         end
      endcase
   end

   assign pc         = r_pc;
   assign pc_valid   = (r_state == ST_RUN);
   assign halted     = (r_state == ST_HALT);
   assign jump_taken = r_jump_taken;
   assign retired    = r_retired;
   assign dbg_state  = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios and random stimulus compared
// against a behavioural model of the fetch-address sequence.
module tb_pc_sequencer;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 15;
   localparam int CNT_W  = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] target;
   logic              is_c;
   logic [2:0]        jmp;
   logic              zr;
   logic              ng;
   logic              stall;
   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic              jump_taken;
   logic              halted;
   logic [CNT_W-1:0]  retired;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // model of the architectural view
   bit m_live;
   bit m_halted;
   int m_pc;
   bit m_jt;
   int m_retired;

   pc_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .target     (target),
      .is_c       (is_c),
      .jmp        (jmp),
      .zr         (zr),
      .ng         (ng),
      .stall      (stall),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .jump_taken (jump_taken),
      .halted     (halted),
      .retired    (retired),
      .dbg_state  (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock of stimulus; model advances on the same edge, outputs checked #1 after.
   task automatic step(input bit rst, input logic [15:0] tgt, input bit c,
                       input logic [2:0] j, input bit z, input bit n, input bit st);
      bit take;
      @(negedge clk);
      reset = rst; target = tgt; is_c = c; jmp = j; zr = z; ng = n; stall = st;
      take = c && ((j[2] && n) || (j[1] && z) || (j[0] && !n && !z));
      if (rst) begin
         m_live = 0; m_halted = 0; m_pc = 0; m_jt = 0; m_retired = 0;
      end else if (!m_live && !m_halted) begin
         m_live = 1;
      end else if (m_live && !st) begin
         m_retired = (m_retired == CNT_MAX) ? CNT_MAX : m_retired + 1;
         if (take) begin
            if (int'(tgt % 32768) == m_pc) begin
               m_halted = 1;
               m_live   = 0;
            end
            m_pc = tgt % 32768;
            m_jt = 1;
         end else begin
            m_pc = (m_pc + 1) % 32768;
            m_jt = 0;
         end
      end
      @(posedge clk);
      #1;
      check_eq("pc", 32'(pc), 32'(m_pc));
      check_eq("pc_valid", 32'(pc_valid), 32'(m_live));
      check_eq("jump_taken", 32'(jump_taken), 32'(m_jt));
      check_eq("halted", 32'(halted), 32'(m_halted));
      check_eq("retired", 32'(retired), 32'(m_retired));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 16'h0, 0, 3'b000, 0, 0, 0);
   endtask

   task automatic jump_to(input logic [15:0] a);
      step(0, a, 1, 3'b111, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; target = '0; is_c = 0; jmp = '0; zr = 0; ng = 0; stall = 0;

      // 1: reset, release, linear fetch
      step(1, 16'h0, 0, 3'b000, 0, 0, 0);
      step(1, 16'h0, 0, 3'b000, 0, 0, 0);
      check_eq("t1_rst_pc_valid", 32'(pc_valid), 32'd0);
      idle(5);
      check_eq("t1_pc4", 32'(pc), 32'h4);
      check_eq("t1_ret4", 32'(retired), 32'd4);

      // 2: JEQ taken / not taken, target MSB dropped
      jump_to(16'h0010);
      step(0, 16'h8123, 1, 3'b010, 1, 0, 0);
      check_eq("t2_pc_taken", 32'(pc), 32'h0123);
      check_eq("t2_jt_taken", 32'(jump_taken), 32'd1);
      jump_to(16'h0010);
      step(0, 16'h8123, 1, 3'b010, 0, 0, 0);
      check_eq("t2_pc_fall", 32'(pc), 32'h0011);
      check_eq("t2_jt_fall", 32'(jump_taken), 32'd0);

      // 3: wrap and A-instruction with jump bits set
      jump_to(16'h7FFF);
      step(0, 16'h1234, 0, 3'b000, 0, 0, 0);
      check_eq("t3_wrap", 32'(pc), 32'h0);
      step(0, 16'h1234, 0, 3'b111, 0, 0, 0);
      check_eq("t3_notc", 32'(pc), 32'h1);

      // 4: stall with pending jump
      for (int i = 0; i < 3; i++) step(0, 16'h0100, 1, 3'b111, 0, 0, 1);
      check_eq("t4_hold_pc", 32'(pc), 32'h1);
      step(0, 16'h0100, 1, 3'b111, 0, 0, 0);
      check_eq("t4_release", 32'(pc), 32'h0100);

      // 5: jump-to-self halt, then reset
      jump_to(16'h0042);
      jump_to(16'h0042);
      check_eq("t5_halted", 32'(halted), 32'd1);
      check_eq("t5_pc", 32'(pc), 32'h42);
      for (int i = 0; i < 4; i++)
         step(0, 16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step(1, 16'h0, 0, 3'b000, 0, 0, 0);
      check_eq("t5_reset_halt", 32'(halted), 32'd0);

      // 6: reset during stall
      idle(6);
      step(0, 16'h0200, 1, 3'b111, 0, 0, 1);
      step(1, 16'h0200, 1, 3'b111, 0, 0, 1);
      check_eq("t6_pc", 32'(pc), 32'h0);
      check_eq("t6_dbg_state_rst", 32'(dbg_state), 32'd0);

      // random: occasional resets
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 99) == 0, 16'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);

      // long run without reset so the retired counter saturates
      step(1, 16'h0, 0, 3'b000, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         step(0, 16'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
      if (!m_halted) check_eq("sat_retired", 32'(retired), 32'(CNT_MAX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
